spinv_input_ctrl: RTL and testbench

Input conditioning and game-rate stage feeding `ee354_spinvaders_sm`. It synchronizes and debounces the three raw push-buttons (left, right, fire) and generates a periodic `game_tick`. It emits `L`, `R` and `shoot` only on tick cycles, so the downstream state machine moves the ship and launches projectiles at game rate instead of every `Clk` edge.

---
 rtl/spinv_pkg.sv | 29 ++
 rtl/spinv_debounce.sv | 117 +++++++++++
 rtl/spinv_input_ctrl.sv | 148 ++++++++++++++
 tb/tb_spinv_input_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/spinv_pkg.sv
// -----------------------------------------------------------------------------
// spinv_pkg
// Shared definitions for the Space Invaders input path and game FSM:
//   - db_state_e : debounce FSM state encoding {LOW, ARM_HI, HIGH, ARM_LO}
//   - DEF_*      : default values for the input-conditioning parameters
//   - SHIP_STEP, PROJ_IDLE_X : geometry constants used by ee354_spinvaders_sm
//   - cnt_w()    : counter width for a modulus, never narrower than 1 bit
// -----------------------------------------------------------------------------
package spinv_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    ARM_HI = 2'd1,
    HIGH   = 2'd2,
    ARM_LO = 2'd3
  } db_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_TICK_DIV        = 416667;
  localparam int DEF_AUTOFIRE_TICKS  = 8;

  localparam int SHIP_STEP   = 5;
  localparam int PROJ_IDLE_X = 900;

  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spinv_debounce.sv
// -----------------------------------------------------------------------------
// spinv_debounce
// One push-button channel: 2-flop synchronizer followed by a four-state
// debounce FSM. A level change is accepted after DEBOUNCE_CYCLES consecutive
// stable synchronized samples, so a clean raw edge reaches `level` exactly
// 2 + DEBOUNCE_CYCLES rising edges later.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable samples required to accept a change (>= 2)
// Ports:
//   Clk   in  1 : system clock
//   reset in  1 : asynchronous, active-high
//   btn   in  1 : raw button, asynchronous to Clk
//   level out 1 : debounced level (1 in HIGH and ARM_LO)
//   rise  out 1 : one-cycle pulse, coincident with level going 1
// -----------------------------------------------------------------------------
module spinv_debounce
  import spinv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  // The entry transition into an ARM state is itself the first stable
  // sample, so the count that completes the window is DEBOUNCE_CYCLES-2.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("spinv_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  logic      sync_p0;
  logic      sync_p1;
  db_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic      rise_nx;

  // ---- stage p0/p1: metastability synchronizer ----
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: debounce FSM on the synchronized level ----
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= LOW;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rise  <= rise_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise_nx  = 1'b0;
    case (state)
      LOW: begin
        if (sync_p1) begin
          state_nx = ARM_HI;
          cnt_nx   = '0;
        end
      end
      ARM_HI: begin
        if (!sync_p1) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (!sync_p1) begin
          state_nx = ARM_LO;
          cnt_nx   = '0;
        end
      end
      ARM_LO: begin
        if (sync_p1) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  assign level = (state == HIGH) || (state == ARM_LO);

endmodule

// File: rtl/spinv_input_ctrl.sv
// -----------------------------------------------------------------------------
// spinv_input_ctrl
// Input conditioning and game-rate stage in front of ee354_spinvaders_sm.
// Three debounced buttons (left, right, fire) are gated by a free-running
// game_tick so the game FSM moves and fires at game rate, not every Clk edge.
//
// Build option:
//   SPINV_AUTOFIRE_EN : when defined, holding fire repeats a shot every
//                       AUTOFIRE_TICKS game ticks after the initial shot.
//                       When undefined, each debounced press gives one shot.
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized cycles to accept a change (>= 2)
//   TICK_DIV        : Clk cycles per game_tick (>= 2)
//   AUTOFIRE_TICKS  : ticks between repeat shots (>= 1, autofire build only)
// Ports:
//   Clk       in  1 : system clock
//   reset     in  1 : asynchronous, active-high
//   BtnL      in  1 : raw left button
//   BtnR      in  1 : raw right button
//   BtnC      in  1 : raw fire button
//   game_tick out 1 : one-cycle pulse every TICK_DIV cycles
//   L         out 1 : move-left strobe (tick-qualified, not with right held)
//   R         out 1 : move-right strobe (tick-qualified, not with left held)
//   shoot     out 1 : fire strobe (tick-qualified)
//   btn_state out 3 : debounced levels {C,R,L}
// -----------------------------------------------------------------------------
module spinv_input_ctrl
  import spinv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int AUTOFIRE_TICKS  = DEF_AUTOFIRE_TICKS
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnC,
  output logic       game_tick,
  output logic       L,
  output logic       R,
  output logic       shoot,
  output logic [2:0] btn_state
);

  if (TICK_DIV < 2) begin : g_chk_tick
    $error("spinv_input_ctrl: TICK_DIV must be >= 2");
  end
  if (AUTOFIRE_TICKS < 1) begin : g_chk_af
    $error("spinv_input_ctrl: AUTOFIRE_TICKS must be >= 1");
  end

  localparam int TW = cnt_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic          dbL, dbR, dbC;
  logic          riseL, riseR, riseC;
  logic [TW-1:0] tick_cnt;
  logic          pend;
  logic          af_fire;

  // ---- stages p0..p2: per-button synchronizer and debounce ----
  spinv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .Clk   (Clk),
    .reset (reset),
    .btn   (BtnL),
    .level (dbL),
    .rise  (riseL)
  );

  spinv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .Clk   (Clk),
    .reset (reset),
    .btn   (BtnR),
    .level (dbR),
    .rise  (riseR)
  );

  spinv_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
    .Clk   (Clk),
    .reset (reset),
    .btn   (BtnC),
    .level (dbC),
    .rise  (riseC)
  );

  // Direction edges are not needed: movement follows the held level.
  logic unused_rise;
  assign unused_rise = riseL ^ riseR;

  // ---- game-rate tick generator ----
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (game_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign game_tick = (tick_cnt == TICK_LAST);

  // ---- fire request capture and tick-qualified strobes ----
  // A rise landing on the tick fires immediately; otherwise it waits in pend.
  // Several rises before the tick collapse into the one pending shot.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (shoot) begin
      pend <= 1'b0;
    end else if (riseC) begin
      pend <= 1'b1;
    end
  end

`ifdef SPINV_AUTOFIRE_EN
  localparam int AW = cnt_w(AUTOFIRE_TICKS + 1);
  localparam logic [AW-1:0] AF_RELOAD = AW'(AUTOFIRE_TICKS);

  // Nonzero af_cnt means autofire is armed; it is loaded by the press's
  // first shot and counts game ticks down, firing on the tick that would
  // take it to zero and reloading in the same step.
  logic [AW-1:0] af_cnt;

  assign af_fire = (af_cnt == AW'(1));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      af_cnt <= '0;
    end else if (!dbC) begin
      af_cnt <= '0;
    end else if (game_tick && (pend || riseC)) begin
      af_cnt <= AF_RELOAD;
    end else if (game_tick && (af_cnt != '0)) begin
      af_cnt <= af_fire ? AF_RELOAD : (af_cnt - AW'(1));
    end
  end
`else
  assign af_fire = 1'b0;
`endif

  assign shoot     = game_tick & (pend | riseC | af_fire);
  assign L         = game_tick & dbL & ~dbR;
  assign R         = game_tick & dbR & ~dbL;
  assign btn_state = {dbC, dbR, dbL};

endmodule

// File: tb/tb_spinv_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spinv_input_ctrl
// Directed bench for spinv_input_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=10,
// AUTOFIRE_TICKS=3. Inputs change and outputs are sampled on the falling
// edge; `e` counts rising edges since the last reset release. A clean raw
// interval [s,t) set at those falling edges shows up debounced as [s+6,t+6),
// and game_tick is high when e%10 == 9.
// -----------------------------------------------------------------------------
module tb_spinv_input_ctrl;

  logic       Clk;
  logic       reset;
  logic       BtnL, BtnR, BtnC;
  logic       game_tick, L, R, shoot;
  logic [2:0] btn_state;

  int e;
  int n_chk;
  int n_fail;

  spinv_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .TICK_DIV        (10),
    .AUTOFIRE_TICKS  (3)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .BtnL      (BtnL),
    .BtnR      (BtnR),
    .BtnC      (BtnC),
    .game_tick (game_tick),
    .L         (L),
    .R         (R),
    .shoot     (shoot),
    .btn_state (btn_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s e=%0d got=%0h exp=%0h", tag, e, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    e++;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_tick"},  32'(game_tick), 32'(0));
    chk({tag, "_L"},     32'(L),         32'(0));
    chk({tag, "_R"},     32'(R),         32'(0));
    chk({tag, "_shoot"}, 32'(shoot),     32'(0));
    chk({tag, "_state"}, 32'(btn_state), 32'(0));
  endtask

  function automatic bit in_rng(input int x, input int s, input int t);
    return (x >= s) && (x < t);
  endfunction

  // Raw stimulus for the main timeline.
  function automatic logic raw_c(input int x);
    return in_rng(x, 0, 3) || in_rng(x, 4, 7) || in_rng(x, 20, 26) ||
           in_rng(x, 64, 68) || in_rng(x, 72, 76) || in_rng(x, 83, 87) ||
           in_rng(x, 220, 420) || in_rng(x, 455, 461);
  endfunction
  function automatic logic raw_l(input int x);
    return in_rng(x, 110, 160);
  endfunction
  function automatic logic raw_r(input int x);
    return in_rng(x, 110, 200);
  endfunction

  // Hand-derived debounced levels (the 3-high/1-low/3-high burst never lands).
  function automatic logic exp_dc(input int x);
    return in_rng(x, 26, 32) || in_rng(x, 70, 74) || in_rng(x, 78, 82) ||
           in_rng(x, 89, 93) || in_rng(x, 226, 426) || in_rng(x, 461, 467);
  endfunction
  function automatic logic exp_dl(input int x);
    return in_rng(x, 116, 166);
  endfunction
  function automatic logic exp_dr(input int x);
    return in_rng(x, 116, 206);
  endfunction

  // Shots: 29 (after 6-cycle hold), 79 (two presses merged), 89 (rise on
  // the tick), 229 (long hold), and repeats every 3 ticks with autofire.
  function automatic logic exp_shoot(input int x);
    case (x)
      29, 79, 89, 229: return 1'b1;
`ifdef SPINV_AUTOFIRE_EN
      259, 289, 319, 349, 379, 409: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Both directions held cancel; only ticks 169..199 give R.
  function automatic logic exp_r(input int x);
    return (x == 169) || (x == 179) || (x == 189) || (x == 199);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    e      = 0;
    reset  = 1'b1;
    BtnL   = 1'b0;
    BtnR   = 1'b0;
    BtnC   = 1'b0;

    repeat (3) @(negedge Clk);
    chk_quiet("in_reset");

    // Release and hold left from cycle 0.
    reset = 1'b0;
    e     = 0;
    BtnL  = 1'b1;
    chk_quiet("release");
    for (int k = 0; k < 39; k++) begin
      step();
      chk("A_tick",  32'(game_tick),    32'(e % 10 == 9));
      chk("A_dbL",   32'(btn_state),    32'((e >= 6) ? 1 : 0));
      chk("A_L",     32'(L),            32'((e % 10 == 9) && (e >= 6)));
      chk("A_R",     32'(R),            32'(0));
      chk("A_shoot", 32'(shoot),        32'(0));
    end

    // e=39: tick and L are high; an asynchronous reset must clear them now.
    #2 reset = 1'b1;
    BtnL = 1'b0;
    #1 chk_quiet("async_rst");
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    e     = 0;
    chk_quiet("release2");

    // Main timeline: fire patterns, both-direction hold, long fire hold.
    for (int k = 0; k < 465; k++) begin
      BtnC = raw_c(e);
      BtnL = raw_l(e);
      BtnR = raw_r(e);
      step();
      chk("M_tick",  32'(game_tick), 32'(e % 10 == 9));
      chk("M_state", 32'(btn_state), 32'({exp_dc(e), exp_dr(e), exp_dl(e)}));
      chk("M_L",     32'(L),         32'(0));
      chk("M_R",     32'(R),         32'(exp_r(e)));
      chk("M_shoot", 32'(shoot),     32'(exp_shoot(e)));
    end

    // e=465: fire accepted at 461 with a shot pending for tick 469.
    chk("pre_rst_state", 32'(btn_state), 32'(3'b100));
    #2 reset = 1'b1;
    BtnC = 1'b0;
    #1 chk_quiet("rst_pend");
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    e     = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      chk("P_tick",  32'(game_tick), 32'(e % 10 == 9));
      chk("P_shoot", 32'(shoot),     32'(0));
      chk("P_state", 32'(btn_state), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
